// File: rtl/y_signature_misr_if.sv
// y_signature_misr_if: bundles the sample stream and the result signals that
// pass between a stimulus/response source and the signature compactor.
//   start, y_valid, y, expected_sig : driven by the master (source side)
//   busy, done, pass, signature, sample_cnt : driven by the slave (compactor)
// CNT_WIDTH must equal $clog2(NUM_SAMPLES+1) of the attached compactor.
interface y_signature_misr_if #(
  parameter int Y_WIDTH   = 552,
  parameter int SIG_WIDTH = 32,
  parameter int CNT_WIDTH = 5
);
  logic                 start;
  logic                 y_valid;
  logic [Y_WIDTH-1:0]   y;
  logic [SIG_WIDTH-1:0] expected_sig;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] signature;
  logic [CNT_WIDTH-1:0] sample_cnt;

  modport master (
    output start, y_valid, y, expected_sig,
    input  busy, done, pass, signature, sample_cnt
  );

  modport slave (
    input  start, y_valid, y, expected_sig,
    output busy, done, pass, signature, sample_cnt
  );
endinterface

// File: rtl/y_signature_misr.sv
// y_signature_misr: compacts the wide y response bus of the design under
// equivalence test into a SIG_WIDTH-bit MISR signature over a window of
// NUM_SAMPLES valid samples, then compares it with a golden value.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, overrides everything
//   bus  - slave modport: start / y_valid / y / expected_sig in,
//          busy / done / pass / signature / sample_cnt out (all registered)
module y_signature_misr #(
  parameter int                   Y_WIDTH     = 552,
  parameter int                   SIG_WIDTH   = 32,
  parameter int                   NUM_SAMPLES = 20,
  parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED        = 32'h00000000
) (
  input logic              clk,
  input logic              rst,
  y_signature_misr_if.slave bus
);

  localparam int CNT_WIDTH  = $clog2(NUM_SAMPLES + 1);
  localparam int NUM_CHUNKS = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int EXT_WIDTH  = NUM_CHUNKS * SIG_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic                 busy_q, done_q;

  logic [EXT_WIDTH-1:0] y_ext;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;

  // Zero-extend y to a whole number of chunks, then XOR the chunks together.
  always_comb begin
    y_ext = '0;
    y_ext[Y_WIDTH-1:0] = bus.y;
    fold = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      fold = fold ^ y_ext[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  // One Galois-style MISR step: shift left, fold in the polynomial when the
  // top bit falls out, and mix in the folded sample.
  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;

  // Next-state logic. start always wins over y_valid, so a restart never
  // absorbs the sample presented in the same cycle. The pass verdict is
  // computed from the updated signature and the expected_sig present on the
  // completing edge only.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.start) begin
          sig_d = SEED;
          cnt_d = '0;
        end else if (bus.y_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            pass_d  = (misr_next == bus.expected_sig);
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sig_d   = SEED;
        cnt_d   = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; busy/done are registered copies of the
  // next-state decode so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.signature  = sig_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_y_signature_misr.sv
// tb_y_signature_misr: randomized scoreboard bench for y_signature_misr.
// Two instances: the default 20-sample window (seed 0) and a 1-sample window
// seeded with 32'h80000000 to exercise the single-sample boundary.
module tb_y_signature_misr;

  localparam int YW   = 552;
  localparam int SW   = 32;
  localparam int NS   = 20;
  localparam int CW   = $clog2(NS + 1);
  localparam int NCH  = (YW + SW - 1) / SW;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED0 = 32'h00000000;
  localparam logic [31:0] SEED1 = 32'h80000000;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  bit   prev_done0 = 1'b0;
  bit   prev_done1 = 1'b0;

  always #5 clk = ~clk;

  y_signature_misr_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus0 ();
  y_signature_misr_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(1))  bus1 ();

  y_signature_misr #(
    .Y_WIDTH(YW), .SIG_WIDTH(SW), .NUM_SAMPLES(NS), .POLY(POLY), .SEED(SEED0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  y_signature_misr #(
    .Y_WIDTH(YW), .SIG_WIDTH(SW), .NUM_SAMPLES(1), .POLY(POLY), .SEED(SEED1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Reference fold: XOR of every 32-bit slice of the zero-extended bus.
  function automatic logic [31:0] foldRef(input logic [YW-1:0] v);
    logic [NCH*SW-1:0] ext;
    logic [31:0]       acc;
    ext = '0;
    ext[YW-1:0] = v;
    acc = '0;
    for (int i = 0; i < NCH; i++) acc = acc ^ ext[i*SW +: SW];
    return acc;
  endfunction

  // Reference MISR: multiply by x modulo the polynomial, then add the fold.
  function automatic logic [31:0] stepRef(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] times_x;
    times_x = s << 1;
    if (s[31]) times_x = times_x ^ POLY;
    return times_x ^ f;
  endfunction

  function automatic logic [YW-1:0] randY();
    logic [NCH*SW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*SW +: SW] = $urandom;
    return r[YW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive the main instance's inputs, then let one rising edge pass.
  task automatic applyStimulus(input logic st, input logic v,
                               input logic [YW-1:0] yy, input logic [31:0] es);
    bus0.start        = st;
    bus0.y_valid      = v;
    bus0.y            = yy;
    bus0.expected_sig = es;
    @(negedge clk);
  endtask

  // Scoreboard monitors: compare on every rising edge of done.
  always @(negedge clk) begin
    if (bus0.done === 1'b1 && !prev_done0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone0 actual=1 required=0");
      end else begin
        e0 = q0.pop_front();
        checkOutput("sb0_signature", bus0.signature, e0.sig);
        checkOutput("sb0_pass", bus0.pass, e0.pass);
        checkOutput("sb0_sample_cnt", bus0.sample_cnt, e0.cnt);
      end
    end
    prev_done0 = (bus0.done === 1'b1);
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1 && !prev_done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone1 actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        checkOutput("sb1_signature", bus1.signature, e1.sig);
        checkOutput("sb1_pass", bus1.pass, e1.pass);
        checkOutput("sb1_sample_cnt", bus1.sample_cnt, e1.cnt);
      end
    end
    prev_done1 = (bus1.done === 1'b1);
  end

  // One capture window on the main instance. restart_at / rst_at inject a
  // restart or a reset after that many absorbed samples (-1 = never).
  task automatic runWindow(input bit gapped, input bit zero_data, input bit match,
                           input int restart_at, input int rst_at);
    logic [31:0]   msig;
    logic [31:0]   es;
    logic [YW-1:0] yy;
    int            mcnt;
    int            budget;
    int            restart;
    bit            v;
    restart = restart_at;
    applyStimulus(1'b1, 1'b1, randY(), $urandom);
    msig = SEED0;
    mcnt = 0;
    checkOutput("busyAfterStart", bus0.busy, 1);
    checkOutput("doneAfterStart", bus0.done, 0);
    checkOutput("passAfterStart", bus0.pass, 0);
    checkOutput("sigAfterStart", bus0.signature, msig);
    checkOutput("cntAfterStart", bus0.sample_cnt, 0);
    budget = 0;
    while (mcnt < NS) begin
      budget++;
      if (budget > 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL windowBudget actual=%0d required<=300", budget);
        return;
      end
      if (restart >= 0 && mcnt == restart) begin
        restart = -1;
        applyStimulus(1'b1, 1'b1, randY(), $urandom);
        msig = SEED0;
        mcnt = 0;
        checkOutput("cntAfterRestart", bus0.sample_cnt, 0);
        checkOutput("sigAfterRestart", bus0.signature, msig);
        continue;
      end
      if (rst_at >= 0 && mcnt == rst_at) begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, randY(), $urandom);
        rst = 1'b0;
        checkOutput("busyAfterRst", bus0.busy, 0);
        checkOutput("doneAfterRst", bus0.done, 0);
        checkOutput("sigAfterRst", bus0.signature, SEED0);
        checkOutput("cntAfterRst", bus0.sample_cnt, 0);
        return;
      end
      v  = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      yy = zero_data ? '0 : randY();
      es = $urandom;
      if (v) begin
        msig = stepRef(msig, foldRef(yy));
        mcnt++;
        if (mcnt == NS) begin
          es = match ? msig : (msig ^ (32'h1 << $urandom_range(0, 31)));
          q0.push_back('{sig: msig, pass: match, cnt: NS});
        end
      end
      applyStimulus(1'b0, v, yy, es);
      if (mcnt < NS) begin
        checkOutput("cntRunning", bus0.sample_cnt, mcnt);
        checkOutput("sigRunning", bus0.signature, msig);
        checkOutput("doneRunning", bus0.done, 0);
      end
    end
    checkOutput("doneLatency", bus0.done, 1);
    // Result must stay frozen while samples and expected_sig keep moving.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, randY(), $urandom);
      checkOutput("frozenSig", bus0.signature, msig);
      checkOutput("frozenPass", bus0.pass, match);
      checkOutput("frozenCnt", bus0.sample_cnt, NS);
    end
  endtask

  // One window on the single-sample instance; req_sig is the hand-derived value.
  task automatic runSmall(input logic [YW-1:0] yy, input bit match, input logic [31:0] req_sig);
    logic [31:0] msig;
    bus1.start = 1'b1;
    bus1.y_valid = 1'b0;
    @(negedge clk);
    checkOutput("smallBusy", bus1.busy, 1);
    msig = stepRef(SEED1, foldRef(yy));
    q1.push_back('{sig: msig, pass: match, cnt: 1});
    bus1.start = 1'b0;
    bus1.y_valid = 1'b1;
    bus1.y = yy;
    bus1.expected_sig = match ? msig : ~msig;
    @(negedge clk);
    bus1.y_valid = 1'b0;
    checkOutput("smallDone", bus1.done, 1);
    checkOutput("smallSigConst", bus1.signature, req_sig);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [YW-1:0] y32;
    bus1.start = 1'b0;
    bus1.y_valid = 1'b0;
    bus1.y = '0;
    bus1.expected_sig = '0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, randY(), 32'h0);
    applyStimulus(1'b1, 1'b1, randY(), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, randY(), $urandom);
      checkOutput("resetSig", bus0.signature, SEED0);
      checkOutput("resetCnt", bus0.sample_cnt, 0);
      checkOutput("resetBusy", bus0.busy, 0);
      checkOutput("resetDone", bus0.done, 0);
      checkOutput("resetPass", bus0.pass, 0);
    end
    $display("[TB] zero-data window");
    runWindow(1'b0, 1'b1, 1'b1, -1, -1);
    $display("[TB] random windows");
    runWindow(1'b0, 1'b0, 1'b1, -1, -1);
    runWindow(1'b1, 1'b0, 1'b0, -1, -1);
    runWindow(1'b1, 1'b0, 1'b1, -1, -1);
    $display("[TB] mid-window reset and restart");
    runWindow(1'b0, 1'b0, 1'b1, -1, 3);
    runWindow(1'b1, 1'b0, 1'b1, 5, -1);
    runWindow(1'b0, 1'b0, 1'b0, 5, -1);
    $display("[TB] single-sample boundary");
    runSmall('0, 1'b1, 32'h04C11DB7);
    y32 = '0;
    y32[32] = 1'b1;
    runSmall(y32, 1'b0, 32'h04C11DB6);
    checkOutput("scoreboard0Drained", q0.size(), 0);
    checkOutput("scoreboard1Drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y_signature_misr.md
Name: y_signature_misr

Overview:
- Downstream response compactor for the fuzzed `top` design under equivalence test.
- Samples the wide `y` output bus once per clock while a capture window is open, and folds each sample to SIG_WIDTH bits.
- Accumulates the folded samples into a multiple-input signature register (MISR).
- After NUM_SAMPLES samples, compares the signature against a golden value, so synthesized and reference netlists can be checked in hardware without per-cycle strobe dumps.

Parameters:
- Y_WIDTH, 552: width of the consumed `y` bus.
- SIG_WIDTH, 32: signature width.
- NUM_SAMPLES, 20: number of valid samples per capture window; must be >= 1.
- POLY, 32'h04C11DB7: MISR feedback polynomial taps, SIG_WIDTH bits.
- SEED, 32'h00000000: signature value loaded on reset and on start.

Ports:
- clk  input  1  rising-edge clock, same clock that drives `top`.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a capture window.
- y_valid  input  1  `y` holds a sample to be absorbed this cycle.
- y  input  Y_WIDTH  response bus from `top`.
- expected_sig  input  SIG_WIDTH  golden signature; sampled when the window completes.
- busy  output  1  capture window open (RUN state).
- done  output  1  window complete; result valid (DONE state).
- pass  output  1  signature == expected_sig; valid only while done=1.
- signature  output  SIG_WIDTH  current MISR contents.
- sample_cnt  output  $clog2(NUM_SAMPLES+1)  samples absorbed in the current window.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, signature=SEED, sample_cnt=0, busy=0, done=0, pass=0.
  - rst takes priority over every other input, including mid-window; a partial window is discarded.
- Fold:
  - Zero-extend y to ceil(Y_WIDTH/SIG_WIDTH)*SIG_WIDTH bits (18 chunks at the defaults).
  - fold = XOR of all SIG_WIDTH-bit chunks; chunk 0 = y[SIG_WIDTH-1:0].
  - Purely combinational, no added latency.
- MISR update, on a clk edge in RUN with y_valid=1:
  - signature <= {signature[SIG_WIDTH-2:0],1'b0} ^ (signature[SIG_WIDTH-1] ? POLY : 0) ^ fold.
  - sample_cnt <= sample_cnt+1.
  - With y_valid=0, signature and sample_cnt hold.
- FSM:
  - IDLE: start=1 -> RUN, signature<=SEED, sample_cnt<=0. y_valid is ignored in IDLE.
  - RUN: on a valid sample with sample_cnt==NUM_SAMPLES-1, absorb that sample and -> DONE in the same edge. pass <= (updated signature == expected_sig), with expected_sig sampled at that edge.
  - RUN + start=1: restart the window (signature<=SEED, sample_cnt<=0, stay RUN). The sample presented that cycle is not absorbed; start wins over y_valid.
  - DONE: done=1; signature, sample_cnt and pass are frozen. y_valid is ignored. start=1 -> RUN with a fresh window (done and pass drop to 0 at that edge).
- Timing:
  - busy = (state==RUN); done = (state==DONE).
  - All outputs are registered.
  - done rises on the edge that absorbs sample NUM_SAMPLES, so the result is visible 1 cycle after the last valid sample is presented.
- sample_cnt never exceeds NUM_SAMPLES; no wrap-around.
- expected_sig changes while in RUN have no effect on the result.

Test Plan:
1. rst=1 for 2 cycles, then start; all outputs stay at their reset values until start -> signature=0, sample_cnt=0, busy=0, done=0, pass=0.
2. NUM_SAMPLES=20, SEED=0, y=0, y_valid=1 for 20 cycles, expected_sig=0 -> done=1 exactly 20 cycles after busy rises; signature=0, pass=1, sample_cnt=20.
3. NUM_SAMPLES=2, SEED=0, y=1 twice -> signature=32'h1 after sample 1, 32'h3 at done. With expected_sig=32'h3: pass=1. With expected_sig=32'h2: pass=0.
4. NUM_SAMPLES=1, SEED=32'h80000000, y=0 -> signature=32'h04C11DB7. Repeat with y having only bit 32 set (fold=1) -> 32'h04C11DB6.
5. NUM_SAMPLES=4, y_valid gapped as 1,0,0,1,1,0,1 -> done after the 4th valid sample; signature identical to the ungapped run with the same data.
6. Mid-window events:
   - rst after 3 of 20 samples -> IDLE, signature=SEED, sample_cnt=0.
   - start at sample 5 -> sample_cnt=0, and the final signature matches a clean 20-sample run started at that point.
